// File: rtl/wb_data_reg.sv
// Load-data buffer: picks one source channel, applies load extraction to the memory
// channel, and queues {data, error} entries in a small ready/valid FIFO.
module wb_data_reg #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NSRC    = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned MEM_SRC = 1
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic [$clog2(NSRC)-1:0]       SrcSel,
    input  logic [NSRC*WIDTH-1:0]         SrcData,
    input  logic [2:0]                    LoadMode,
    input  logic [$clog2(WIDTH/8)-1:0]    ByteOff,
    input  logic                          InValid,
    output logic                          InReady,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [WIDTH-1:0]              DBOut,
    output logic                          AlignErr,
    output logic [$clog2(DEPTH+1)-1:0]    Count
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        LdFull   = 3'b000,
        LdHalfS  = 3'b001,
        LdHalfU  = 3'b010,
        LdByteS  = 3'b011,
        LdByteU  = 3'b100
    } load_mode_e;

    logic [31:0]      sel_idx;
    logic [31:0]      off_idx;
    logic [WIDTH-1:0] src_word;
    logic [15:0]      half_val;
    logic [7:0]       byte_val;
    logic [WIDTH-1:0] ext_data;
    logic             ext_err;

    always_comb begin
        sel_idx  = 32'(SrcSel);
        off_idx  = 32'(ByteOff);
        src_word = '0;
        if (sel_idx < NSRC) begin
            src_word = SrcData[sel_idx*WIDTH +: WIDTH];
        end
        half_val = src_word[16*(off_idx >> 1) +: 16];
        byte_val = src_word[8*off_idx +: 8];
        ext_data = src_word;
        ext_err  = 1'b0;
        if (sel_idx >= NSRC) begin
            ext_data = '0;
            ext_err  = 1'b1;
        end else if (sel_idx == MEM_SRC) begin
            case (load_mode_e'(LoadMode))
                LdFull:  ext_err = (ByteOff != '0);
                LdHalfS: begin
                    ext_data = {{(WIDTH-16){half_val[15]}}, half_val};
                    ext_err  = ByteOff[0];
                end
                LdHalfU: begin
                    ext_data = {{(WIDTH-16){1'b0}}, half_val};
                    ext_err  = ByteOff[0];
                end
                LdByteS: ext_data = {{(WIDTH-8){byte_val[7]}}, byte_val};
                LdByteU: ext_data = {{(WIDTH-8){1'b0}}, byte_val};
                // Reserved encodings fall back to a full-word load flagged as an error.
                default: ext_err = 1'b1;
            endcase
        end
    end

    logic [WIDTH-1:0] data_q [DEPTH];
    logic             err_q  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    assign OutValid = (count_q != '0);
    assign InReady  = !Reset && ((32'(count_q) < DEPTH) || OutReady);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;
    assign DBOut    = OutValid ? data_q[rd_ptr_q] : '0;
    assign AlignErr = OutValid && err_q[rd_ptr_q];
    assign Count    = count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= ext_data;
                err_q[wr_ptr_q]  <= ext_err;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_data_reg.sv
// Self-checking bench for wb_data_reg: directed extraction vectors, full-buffer and
// mid-stream reset cases, plus a random wrap-around run on a DEPTH=3 instance.
module tb_wb_data_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic        src_sel;
    logic [63:0] src_data;
    logic [2:0]  load_mode;
    logic [1:0]  byte_off;

    logic        in_valid, in_ready, out_valid, out_ready, align_err;
    logic [31:0] db_out;
    logic [1:0]  count;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, align_err3;
    logic [31:0] db_out3;
    logic [1:0]  count3;

    int n_total = 0;
    int n_bad   = 0;
    int pushed;
    int max3 = 0;

    logic [32:0] sb  [$];
    logic [32:0] sb3 [$];

    localparam int NV = 8;
    logic        v_sel  [NV] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  v_mode [NV] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd1, 3'd0, 3'd6, 3'd3};
    logic [1:0]  v_off  [NV] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [31:0] v_data [NV] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'h000080FF,
                                 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01, 32'h12345678};
    logic        v_err  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    wb_data_reg #(.WIDTH(32), .NSRC(2), .DEPTH(2), .MEM_SRC(1)) u_dut (
        .CLK(clk), .Reset(rst), .SrcSel(src_sel), .SrcData(src_data),
        .LoadMode(load_mode), .ByteOff(byte_off), .InValid(in_valid), .InReady(in_ready),
        .OutValid(out_valid), .OutReady(out_ready), .DBOut(db_out), .AlignErr(align_err),
        .Count(count)
    );

    wb_data_reg #(.WIDTH(32), .NSRC(2), .DEPTH(3), .MEM_SRC(1)) u_dut3 (
        .CLK(clk), .Reset(rst), .SrcSel(src_sel), .SrcData(src_data),
        .LoadMode(load_mode), .ByteOff(byte_off), .InValid(in_valid3), .InReady(in_ready3),
        .OutValid(out_valid3), .OutReady(out_ready3), .DBOut(db_out3),
        .AlignErr(align_err3), .Count(count3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference load extraction, returns {err, data}.
    function automatic logic [32:0] model(input logic sel, input logic [63:0] src,
                                          input logic [2:0] mode, input logic [1:0] off);
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b;
        w = sel ? src[63:32] : src[31:0];
        h = off[1] ? w[31:16] : w[15:0];
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        if (!sel) return {1'b0, w};
        case (mode)
            3'd0:    return {off != 2'd0, w};
            3'd1:    return {off[0], {16{h[15]}}, h};
            3'd2:    return {off[0], 16'h0000, h};
            3'd3:    return {1'b0, {24{b[7]}}, b};
            3'd4:    return {1'b0, 24'h000000, b};
            default: return {1'b1, w};
        endcase
    endfunction

    // Scoreboard: sampled mid-cycle, so Count must equal entries queued so far.
    always @(negedge clk) begin
        logic [32:0] exp;
        if (rst) begin
            sb.delete();
            sb3.delete();
        end else begin
            check("count", 64'(count), 64'(sb.size()));
            check("count3", 64'(count3), 64'(sb3.size()));
            if (32'(count3) > max3) max3 = 32'(count3);
            if (sb.size() == 0) check("empty_out", {31'b0, align_err, db_out}, 64'd0);
            if (sb3.size() == 0) check("empty_out3", {31'b0, align_err3, db_out3}, 64'd0);
            if (in_valid && in_ready) sb.push_back(model(src_sel, src_data, load_mode, byte_off));
            if (in_valid3 && in_ready3)
                sb3.push_back(model(src_sel, src_data, load_mode, byte_off));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("underflow", 64'(out_valid), 64'd0);
                end else begin
                    exp = sb.pop_front();
                    check("pop_data", 64'(db_out), 64'(exp[31:0]));
                    check("pop_err", 64'(align_err), 64'(exp[32]));
                end
            end
            if (out_valid3 && out_ready3) begin
                if (sb3.size() == 0) begin
                    check("underflow3", 64'(out_valid3), 64'd0);
                end else begin
                    exp = sb3.pop_front();
                    check("pop_data3", 64'(db_out3), 64'(exp[31:0]));
                    check("pop_err3", 64'(align_err3), 64'(exp[32]));
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; src_sel = 1'b0; src_data = {32'h80FF7F01, 32'h12345678};
        load_mode = 3'd0; byte_off = 2'd0;
        in_valid = 1'b0; out_ready = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
        cycle();
        cycle();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_db_out", 64'(db_out), 64'd0);
        check("rst_align_err", 64'(align_err), 64'd0);

        // First push right after reset, passthrough channel 0.
        in_valid = 1'b1;
        #1;
        check("first_in_ready", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        check("first_data", 64'(db_out), 64'h12345678);
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_err", 64'(align_err), 64'd0);
        check("first_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        for (int i = 0; i < NV; i++) begin
            src_sel = v_sel[i]; load_mode = v_mode[i]; byte_off = v_off[i];
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            check($sformatf("ext%0d_data", i), 64'(db_out), 64'(v_data[i]));
            check($sformatf("ext%0d_err", i), 64'(align_err), 64'(v_err[i]));
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
        end

        // Full buffer: refuse when not draining, accept push+pop when full.
        src_sel = 1'b0; load_mode = 3'd0; byte_off = 2'd0;
        in_valid = 1'b1; src_data[31:0] = 32'hA;
        cycle();
        src_data[31:0] = 32'hB;
        cycle();
        in_valid = 1'b0;
        check("full_count", 64'(count), 64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; src_data[31:0] = 32'hC;
        #1;
        check("refuse_in_ready", 64'(in_ready), 64'd0);
        cycle();
        check("refuse_count", 64'(count), 64'd2);
        check("refuse_head", 64'(db_out), 64'hA);
        out_ready = 1'b1;
        #1;
        check("pp_in_ready", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        check("pp_count", 64'(count), 64'd2);
        check("pp_head", 64'(db_out), 64'hB);
        cycle();
        cycle();
        out_ready = 1'b0;
        check("drain_count", 64'(count), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);

        // Mid-stream reset drops buffered entries.
        in_valid = 1'b1; src_data[31:0] = 32'h1;
        cycle();
        src_data[31:0] = 32'h2;
        cycle();
        in_valid = 1'b0;
        check("mid_count", 64'(count), 64'd2);
        rst = 1'b1;
        #1;
        check("mid_in_ready", 64'(in_ready), 64'd0);
        cycle();
        rst = 1'b0;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(db_out), 64'd0);
        in_valid = 1'b1; src_data[31:0] = 32'h77;
        cycle();
        in_valid = 1'b0;
        check("post_rst_data", 64'(db_out), 64'h77);
        check("post_rst_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Random interleaved traffic on DEPTH=3 to exercise non-power-of-2 wrap.
        pushed = 0;
        for (int i = 0; i < 300 && (pushed < 10 || count3 != 2'd0); i++) begin
            in_valid3  = (pushed < 10) && ($urandom_range(0, 1) == 1);
            out_ready3 = (pushed >= 10) || ($urandom_range(0, 1) == 1);
            src_sel    = 1'($urandom_range(0, 1));
            load_mode  = 3'($urandom_range(0, 7));
            byte_off   = 2'($urandom_range(0, 3));
            src_data   = {$urandom, $urandom};
            #1;
            if (in_valid3 && in_ready3) pushed++;
            cycle();
        end
        in_valid3 = 1'b0; out_ready3 = 1'b0;
        check("wrap_pushed", 64'(pushed), 64'd10);
        check("wrap_count", 64'(count3), 64'd0);
        check("wrap_left", 64'(sb3.size()), 64'd0);
        check("wrap_max", 64'(max3 > 3), 64'd0);
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
